// File: rtl/solver_phase_sequencer.sv
// solver_phase_sequencer: drives the VXV/MXV unit resets through settle, phase and gap windows of an iterative solve
module solver_phase_sequencer #(
    parameter int ITER_W         = 16,
    parameter int SETTLE_CYCLES  = 2,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ITER_W-1:0] max_iter,
    input  logic              finish,
    input  logic              halt_in,
    input  logic              abort,
    output logic              reset_vXv1,
    output logic              reset_mXv1,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count,
    output logic [2:0]        state
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES)
                             ? ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES)
                             : ((SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        VXV    = 3'd2,
        GAP_A  = 3'd3,
        MXV    = 3'd4,
        GAP_B  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t            cur, nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ITER_W-1:0] limit, iter_inc;
    logic              phase, fin_ok, wd_exp, inc_en, set_conv, set_to;

    assign state = cur;

    // next-state decode; the first phase cycle (cnt==0) masks a stale finish, abort overrides everything
    always_comb begin
        phase    = (cur == VXV) || (cur == MXV);
        fin_ok   = phase && finish && (cnt != '0);
        wd_exp   = phase && (cnt == WD_LAST);
        iter_inc = (&iter_count) ? iter_count : iter_count + ITER_W'(1);
        nxt      = cur;
        inc_en   = 1'b0;
        set_conv = 1'b0;
        set_to   = 1'b0;
        case (cur)
            IDLE:    nxt = start ? SETTLE : IDLE;
            SETTLE:  nxt = (cnt == SETTLE_LAST) ? VXV : SETTLE;
            VXV: begin
                if (fin_ok) begin
                    nxt = GAP_A;
                end else if (wd_exp) begin
                    nxt    = DONE;
                    set_to = 1'b1;
                end
            end
            GAP_A:   nxt = (cnt == GAP_LAST) ? MXV : GAP_A;
            MXV: begin
                if (fin_ok) begin
                    inc_en   = 1'b1;
                    set_conv = halt_in;
                    nxt      = (halt_in || iter_inc >= limit) ? DONE : GAP_B;
                end else if (wd_exp) begin
                    nxt    = DONE;
                    set_to = 1'b1;
                end
            end
            GAP_B:   nxt = (cnt == GAP_LAST) ? VXV : GAP_B;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort && cur != IDLE && cur != DONE) begin
            nxt      = DONE;
            inc_en   = 1'b0;
            set_conv = 1'b0;
            set_to   = 1'b0;
        end
    end

    // state, window counter, solve bookkeeping and outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= IDLE;
            cnt        <= '0;
            limit      <= '0;
            iter_count <= '0;
            converged  <= 1'b0;
            timeout    <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            reset_vXv1 <= 1'b1;
            reset_mXv1 <= 1'b1;
        end else begin
            cur <= nxt;
            cnt <= (nxt != cur || cur == IDLE) ? '0 : cnt + CNT_W'(1);
            if (cur == IDLE && start) begin
                limit      <= (max_iter == '0) ? ITER_W'(1) : max_iter;
                iter_count <= '0;
                converged  <= 1'b0;
                timeout    <= 1'b0;
            end else begin
                if (inc_en) iter_count <= iter_inc;
                if (set_conv) converged <= 1'b1;
                if (set_to) timeout <= 1'b1;
            end
            done       <= (cur == DONE);
            busy       <= (nxt != IDLE);
            reset_vXv1 <= (nxt != VXV);
            reset_mXv1 <= (nxt != MXV);
        end
    end
endmodule

// File: tb/tb_solver_phase_sequencer.sv
// tb_solver_phase_sequencer: scoreboarded state-run checks of the solver phase sequencer
module tb_solver_phase_sequencer;
    localparam logic [2:0] S_IDLE = 3'd0, S_SETTLE = 3'd1, S_VXV = 3'd2, S_GAP_A = 3'd3,
                           S_MXV = 3'd4, S_GAP_B = 3'd5, S_DONE = 3'd6;

    typedef struct {
        logic [2:0] st;
        int         len;
    } run_t;

    logic        clk = 1'b0;
    logic        reset, start, finish, halt_in, abort;
    logic [15:0] max_iter;
    logic [3:0]  max_iter4;
    logic        a_rv, a_rm, a_busy, a_done, a_conv, a_to;
    logic [15:0] a_iter;
    logic [2:0]  a_state;
    logic        b_rv, b_rm, b_busy, b_done, b_conv, b_to;
    logic [3:0]  b_iter;
    logic [2:0]  b_state;
    logic        sel;
    logic        cur_rv, cur_rm, cur_busy, cur_done, cur_conv, cur_to;
    logic [15:0] cur_iter;
    logic [2:0]  cur_state;

    run_t        exp_q[$];
    logic [2:0]  prev_st;
    int          run_len, done_cnt, fin_v, fin_m;
    logic        rst_bad, track_en, fin_idle, halt_en;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    solver_phase_sequencer dut_a (
        .clk(clk), .reset(reset), .start(start), .max_iter(max_iter), .finish(finish),
        .halt_in(halt_in), .abort(abort), .reset_vXv1(a_rv), .reset_mXv1(a_rm), .busy(a_busy),
        .done(a_done), .converged(a_conv), .timeout(a_to), .iter_count(a_iter), .state(a_state)
    );

    solver_phase_sequencer #(.ITER_W(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .max_iter(max_iter4), .finish(finish),
        .halt_in(halt_in), .abort(abort), .reset_vXv1(b_rv), .reset_mXv1(b_rm), .busy(b_busy),
        .done(b_done), .converged(b_conv), .timeout(b_to), .iter_count(b_iter), .state(b_state)
    );

    always_comb begin
        cur_state = sel ? b_state : a_state;
        cur_iter  = sel ? {12'd0, b_iter} : a_iter;
        cur_rv    = sel ? b_rv : a_rv;
        cur_rm    = sel ? b_rm : a_rm;
        cur_busy  = sel ? b_busy : a_busy;
        cur_done  = sel ? b_done : a_done;
        cur_conv  = sel ? b_conv : a_conv;
        cur_to    = sel ? b_to : a_to;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input int len);
        exp_q.push_back('{st, len});
    endtask

    task automatic exp_run(input int iters, input int fl);
        push(S_SETTLE, 2);
        for (int i = 1; i <= iters; i++) begin
            push(S_VXV, fl);
            push(S_GAP_A, 4);
            push(S_MXV, fl);
            if (i < iters) push(S_GAP_B, 4);
        end
        push(S_DONE, 1);
    endtask

    task automatic tick();
        run_t e;
        @(posedge clk);
        #1;
        if (cur_state != prev_st) begin
            if (track_en && prev_st != S_IDLE) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_run", {29'd0, prev_st}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("run_state", {29'd0, prev_st}, {29'd0, e.st});
                    chk("run_len", run_len, e.len);
                end
            end
            if (track_en && prev_st == S_DONE && cur_state == S_IDLE) chk("done_pulse", {31'd0, cur_done}, 32'd1);
            prev_st = cur_state;
            run_len = 1;
        end else begin
            run_len++;
        end
        if (cur_done) done_cnt++;
        if ((cur_rv !== (cur_state != S_VXV)) || (cur_rm !== (cur_state != S_MXV)) ||
            (cur_busy !== (cur_state != S_IDLE)) || (!cur_rv && !cur_rm)) rst_bad = 1'b1;
        finish  = (cur_state == S_VXV) ? (run_len >= fin_v) :
                  (cur_state == S_MXV) ? (run_len >= fin_m) : fin_idle;
        halt_in = halt_en ? (cur_state == S_MXV && finish) : (cur_state != S_MXV);
    endtask

    task automatic new_test();
        exp_q.delete();
        done_cnt = 0;
        rst_bad  = 1'b0;
    endtask

    task automatic start_run(input logic [15:0] m);
        max_iter  = m;
        max_iter4 = m[3:0];
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int len, input int limit);
        int n = 0;
        while (!(cur_state == st && run_len == len) && n < limit) begin
            tick();
            n++;
        end
        chk("wait_state", {29'd0, cur_state}, {29'd0, st});
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (cur_state != S_IDLE && n < limit) begin
            tick();
            n++;
        end
        chk("reach_idle", {29'd0, cur_state}, {29'd0, S_IDLE});
    endtask

    task automatic end_test();
        tick();
        tick();
        chk("done_count", done_cnt, 1);
        chk("queue_empty", exp_q.size(), 0);
        chk("unit_resets", {31'd0, rst_bad}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; finish = 1'b0; halt_in = 1'b0; abort = 1'b0;
        max_iter = '0; max_iter4 = '0; sel = 1'b0; track_en = 1'b0;
        fin_v = 5; fin_m = 5; fin_idle = 1'b0; halt_en = 1'b0;
        prev_st = S_IDLE; run_len = 0; done_cnt = 0; rst_bad = 1'b0;
        repeat (3) tick();
        chk("rst_state", {29'd0, a_state}, 32'd0);
        chk("rst_rv", {31'd0, a_rv}, 32'd1);
        chk("rst_rm", {31'd0, a_rm}, 32'd1);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_iter", {16'd0, a_iter}, 32'd0);
        chk("rst_b_state", {29'd0, b_state}, 32'd0);
        reset    = 1'b0;
        track_en = 1'b1;

        new_test();
        exp_run(2, 5);
        start_run(16'd2);
        wait_state(S_GAP_A, 1, 50);
        max_iter = 16'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(200);
        chk("t1_iter", {16'd0, cur_iter}, 32'd2);
        chk("t1_conv", {31'd0, cur_conv}, 32'd0);
        chk("t1_to", {31'd0, cur_to}, 32'd0);
        end_test();

        new_test();
        halt_en = 1'b1;
        exp_run(1, 5);
        start_run(16'd10);
        wait_idle(200);
        chk("t2_iter", {16'd0, cur_iter}, 32'd1);
        chk("t2_conv", {31'd0, cur_conv}, 32'd1);
        end_test();
        halt_en = 1'b0;

        new_test();
        fin_idle = 1'b1; fin_v = 0; fin_m = 100000;
        push(S_SETTLE, 2); push(S_VXV, 2); push(S_GAP_A, 4); push(S_MXV, 4096); push(S_DONE, 1);
        start_run(16'd3);
        chk("t3_conv_clr", {31'd0, cur_conv}, 32'd0);
        wait_idle(5000);
        chk("t3_iter", {16'd0, cur_iter}, 32'd0);
        chk("t3_to", {31'd0, cur_to}, 32'd1);
        end_test();
        fin_idle = 1'b0; fin_v = 5; fin_m = 5;

        new_test();
        push(S_SETTLE, 2); push(S_VXV, 5); push(S_GAP_A, 2); push(S_DONE, 1);
        start_run(16'd5);
        chk("t4_to_clr", {31'd0, cur_to}, 32'd0);
        wait_state(S_GAP_A, 2, 50);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_abort", {29'd0, cur_state}, {29'd0, S_DONE});
        wait_idle(20);
        chk("t4_iter", {16'd0, cur_iter}, 32'd0);
        end_test();

        new_test();
        track_en = 1'b0;
        start_run(16'd5);
        for (int n = 0; n < 200 && !(cur_state == S_MXV && cur_iter == 16'd1 && run_len == 3); n++) tick();
        chk("t5_mid_mxv", {16'd0, cur_iter}, 32'd1);
        reset = 1'b1;
        tick();
        chk("t5_state", {29'd0, cur_state}, 32'd0);
        chk("t5_rv", {31'd0, cur_rv}, 32'd1);
        chk("t5_rm", {31'd0, cur_rm}, 32'd1);
        chk("t5_busy", {31'd0, cur_busy}, 32'd0);
        chk("t5_done", {31'd0, cur_done}, 32'd0);
        chk("t5_conv", {31'd0, cur_conv}, 32'd0);
        chk("t5_to", {31'd0, cur_to}, 32'd0);
        chk("t5_iter", {16'd0, cur_iter}, 32'd0);
        start = 1'b1;
        repeat (3) tick();
        chk("t5_hold_state", {29'd0, cur_state}, 32'd0);
        chk("t5_hold_busy", {31'd0, cur_busy}, 32'd0);
        reset = 1'b0;
        tick();
        start = 1'b0;
        chk("t5_restart", {29'd0, cur_state}, {29'd0, S_SETTLE});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort", {29'd0, cur_state}, {29'd0, S_DONE});
        tick();
        chk("t5_idle_done", {31'd0, cur_done}, 32'd1);
        track_en = 1'b1;

        new_test();
        exp_run(1, 5);
        start_run(16'd0);
        wait_idle(200);
        chk("t6_iter", {16'd0, cur_iter}, 32'd1);
        end_test();

        sel      = 1'b1;
        track_en = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        track_en = 1'b1;
        new_test();
        exp_run(15, 5);
        start_run(16'd15);
        wait_idle(1000);
        chk("t7_iter", {16'd0, cur_iter}, 32'd15);
        chk("t7_conv", {31'd0, cur_conv}, 32'd0);
        end_test();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
